// File: rtl/bram_stream_writer_pkg.sv
// Shared constants and state type for the block-memory stream writer and its reader.
// Defaults here size both sides of the memory; override per instance where needed.
package bram_stream_writer_pkg;

  localparam int BSW_ADDR_W = 3;
  localparam int BSW_DATA_W = 4;
  localparam int BSW_DEPTH  = 8;
  localparam int BSW_SUM_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } bsw_state_e;

endpackage

// File: rtl/bram_stream_writer.sv
// Streams DEPTH words from a valid/ready input into port A of a block memory, from address 0.
// Define BRAM_WRITER_CHECKSUM_EN to add the running checksum output.
module bram_stream_writer
  import bram_stream_writer_pkg::*;
#(
  parameter int ADDR_W = BSW_ADDR_W,
  parameter int DATA_W = BSW_DATA_W,
  parameter int DEPTH  = BSW_DEPTH,
  parameter int SUM_W  = BSW_SUM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              done,
`ifdef BRAM_WRITER_CHECKSUM_EN
  output logic [SUM_W-1:0]  checksum,
`endif
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   LP_DEPTH     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_PTR_ONE   = ADDR_W'(1);

  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W) || SUM_W < 1) begin : g_bad_param
    $error("bram_stream_writer: DEPTH must be in 1..2**ADDR_W and SUM_W >= 1");
  end

  // state   | meaning
  // IDLE    | waiting for start, stream not accepted
  // WRITE   | accepting words, one memory write per accept
  // DONE    | run complete, done pulses for this single cycle
  bsw_state_e        r_state;
  logic              r_ena;
  logic              r_wea;
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dina;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_start;
  logic              w_last;
  logic [ADDR_W:0]   w_count_nxt;
  logic [ADDR_W-1:0] w_ptr_nxt;

  assign w_accept    = in_valid && (r_state == S_WRITE);
  assign w_start     = start && (r_state == S_IDLE);
  assign w_count_nxt = r_count + LP_CNT_ONE;
  assign w_ptr_nxt   = r_ptr + LP_PTR_ONE;
  assign w_last      = (w_count_nxt == LP_DEPTH);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ena   <= 1'b0;
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Write strobes default low; addra/dina keep the last written location.
      r_ena  <= 1'b0;
      r_wea  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_WRITE;
            r_count <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (w_accept) begin
            r_ena   <= 1'b1;
            r_wea   <= 1'b1;
            r_addra <= r_ptr;
            r_dina  <= in_data;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRAM_WRITER_CHECKSUM_EN
  logic [SUM_W-1:0] r_checksum;

  always_ff @(posedge clock) begin
    if (reset || w_start) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + SUM_W'(in_data);
    end
  end

  assign checksum = r_checksum;
`endif

  assign in_ready = (r_state == S_WRITE);
  assign ena      = r_ena;
  assign wea      = r_wea;
  assign addra    = r_addra;
  assign dina     = r_dina;
  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;

endmodule

// File: tb/tb_bram_stream_writer.sv
// Directed bench for bram_stream_writer; inputs change and outputs are sampled on the falling edge.
module tb_bram_stream_writer;
  import bram_stream_writer_pkg::*;

  localparam int AW    = BSW_ADDR_W;
  localparam int DW    = BSW_DATA_W;
  localparam int DEPTH = BSW_DEPTH;
  localparam int SW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          ena;
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
`ifdef BRAM_WRITER_CHECKSUM_EN
  logic [SW-1:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [DEPTH];
  int            wr_hits [DEPTH];
  int            bad_we = 0;

  bram_stream_writer #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .SUM_W(SW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .ena      (ena),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina),
    .busy     (busy),
    .done     (done),
`ifdef BRAM_WRITER_CHECKSUM_EN
    .checksum (checksum),
`endif
    .count    (count)
  );

  always #5 clock = ~clock;

  // Behavioural memory behind port A.
  always @(posedge clock) begin
    if (ena && wea) begin
      mem[addra]     <= dina;
      wr_hits[addra] <= wr_hits[addra] + 1;
    end
    if (wea && !ena) bad_we <= bad_we + 1;
  end

  task automatic do_start();
    @(negedge clock);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({ena, wea, busy, done, in_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ena/wea/busy/done/in_ready=%b want 00000", {ena, wea, busy, done, in_ready});
    end
    checks++;
    if (addra !== '0 || dina !== '0 || count !== '0) begin
      errors++;
      $display("FAIL reset_data: addra=%0d dina=%0d count=%0d want 0 0 0", addra, dina, count);
    end
`ifdef BRAM_WRITER_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      errors++;
      $display("FAIL reset_checksum: got %0d want 0", checksum);
    end
`endif
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    int hits0 [DEPTH];
    int done_seen = 0;
    int bad_addr = 0;
    hits0 = wr_hits;
    do_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || ena !== 1'b0) begin
      errors++;
      $display("FAIL basic_start: busy=%b in_ready=%b ena=%b want 1 1 0", busy, in_ready, ena);
    end
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i + 1);
      @(negedge clock);
      if (done) done_seen++;
      checks++;
      if ({ena, wea} !== 2'b11 || addra !== AW'(i) || dina !== DW'(i + 1)) begin
        errors++;
        $display("FAIL basic_write[%0d]: ena=%b wea=%b addra=%0d dina=%0d want 1 1 %0d %0d",
                 i, ena, wea, addra, dina, i, i + 1);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || count !== (AW+1)'(8)) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b in_ready=%b count=%0d want 1 0 0 8", done, busy, in_ready, count);
    end
`ifdef BRAM_WRITER_CHECKSUM_EN
    checks++;
    if (checksum !== SW'(36)) begin
      errors++;
      $display("FAIL basic_checksum: got %0d want %0d", checksum, SW'(36));
    end
`endif
    @(negedge clock);
    if (done) done_seen++;
    checks++;
    if ({ena, wea, done} !== 3'b000 || addra !== AW'(7) || dina !== DW'(8)) begin
      errors++;
      $display("FAIL basic_after: ena=%b wea=%b done=%b addra=%0d dina=%0d want 0 0 0 7 8", ena, wea, done, addra, dina);
    end
    checks++;
    if (done_seen !== 1) begin
      errors++;
      $display("FAIL basic_done_pulses: got %0d want 1", done_seen);
    end
    for (int a = 0; a < DEPTH; a++)
      if (wr_hits[a] - hits0[a] != 1 || mem[a] !== DW'(a + 1)) bad_addr++;
    checks++;
    if (bad_addr !== 0) begin
      errors++;
      $display("FAIL basic_memory: %0d addresses wrong want 0", bad_addr);
    end
  endtask

  task automatic test_backpressure();
    bit pat [12] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    int hits0 [DEPTH];
    int k = 0;
    int bad_addr = 0;
    hits0 = wr_hits;
    do_start();
    for (int c = 0; c < 12; c++) begin
      in_valid = pat[c];
      in_data  = pat[c] ? DW'(5 + k) : 4'hE;
      @(negedge clock);
      checks++;
      if (pat[c]) begin
        if ({ena, wea} !== 2'b11 || addra !== AW'(k) || dina !== DW'(5 + k)) begin
          errors++;
          $display("FAIL bp_write[%0d]: ena=%b wea=%b addra=%0d dina=%0d want 1 1 %0d %0d",
                   c, ena, wea, addra, dina, k, 5 + k);
        end
        k++;
      end else begin
        if ({ena, wea} !== 2'b00 || addra !== AW'(k - 1)) begin
          errors++;
          $display("FAIL bp_gap[%0d]: ena=%b wea=%b addra=%0d want 0 0 %0d", c, ena, wea, addra, k - 1);
        end
      end
    end
    checks++;
    if (count !== (AW+1)'(4) || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_count: count=%0d busy=%b want 4 1", count, busy);
    end
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data  = DW'(j);
      @(negedge clock);
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || count !== (AW+1)'(8)) begin
      errors++;
      $display("FAIL bp_done: done=%b count=%0d want 1 8", done, count);
    end
    @(negedge clock);
    for (int a = 0; a < DEPTH; a++)
      if (wr_hits[a] - hits0[a] != 1) bad_addr++;
    checks++;
    if (bad_addr !== 0) begin
      errors++;
      $display("FAIL bp_unique: %0d addresses not written exactly once want 0", bad_addr);
    end
  endtask

  task automatic test_start_ignored();
    int done_seen = 0;
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i + 2);
      start    = (i == 3);
      @(negedge clock);
      if (done) done_seen++;
      checks++;
      if (ena !== 1'b1 || addra !== AW'(i)) begin
        errors++;
        $display("FAIL si_write[%0d]: ena=%b addra=%0d want 1 %0d", i, ena, addra, i);
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 1) begin
      errors++;
      $display("FAIL si_done_pulses: got %0d want 1", done_seen);
    end
    checks++;
    if (count !== (AW+1)'(8) || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL si_hold: count=%0d busy=%b in_ready=%b want 8 0 0", count, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int hits0 [DEPTH];
    hits0 = wr_hits;
    do_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(10 + i);
      @(negedge clock);
    end
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'(9);
    @(negedge clock);
    checks++;
    if ({ena, wea, busy, done, in_ready} !== 5'b0 || addra !== '0 || dina !== '0 || count !== '0) begin
      errors++;
      $display("FAIL rm_outputs: ena=%b wea=%b busy=%b done=%b in_ready=%b addra=%0d dina=%0d count=%0d want all 0",
               ena, wea, busy, done, in_ready, addra, dina, count);
    end
`ifdef BRAM_WRITER_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      errors++;
      $display("FAIL rm_checksum: got %0d want 0", checksum);
    end
`endif
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (wr_hits[3] - hits0[3] != 0) begin
      errors++;
      $display("FAIL rm_no_addr3: %0d writes to address 3 want 0", wr_hits[3] - hits0[3]);
    end
    checks++;
    if (wr_hits[2] - hits0[2] != 1 || mem[2] !== DW'(12) || mem[0] !== DW'(10)) begin
      errors++;
      $display("FAIL rm_kept: mem0=%0d mem2=%0d hits2=%0d want 10 12 1", mem[0], mem[2], wr_hits[2] - hits0[2]);
    end
  endtask

  task automatic test_wrap();
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 4'hF;
      @(negedge clock);
    end
    in_valid = 1'b0;
    checks++;
    if (addra !== AW'(7) || count !== (AW+1)'(8)) begin
      errors++;
      $display("FAIL wrap_last: addra=%0d count=%0d want 7 8", addra, count);
    end
`ifdef BRAM_WRITER_CHECKSUM_EN
    checks++;
    if (checksum !== SW'(8)) begin
      errors++;
      $display("FAIL wrap_checksum: got %0d want 8", checksum);
    end
`endif
    @(negedge clock);
    do_start();
    in_valid = 1'b1;
    in_data  = DW'(3);
    @(negedge clock);
    checks++;
    if ({ena, wea} !== 2'b11 || addra !== '0 || dina !== DW'(3) || count !== (AW+1)'(1)) begin
      errors++;
      $display("FAIL wrap_restart: ena=%b wea=%b addra=%0d dina=%0d count=%0d want 1 1 0 3 1",
               ena, wea, addra, dina, count);
    end
`ifdef BRAM_WRITER_CHECKSUM_EN
    checks++;
    if (checksum !== SW'(3)) begin
      errors++;
      $display("FAIL wrap_checksum_restart: got %0d want 3", checksum);
    end
`endif
    for (int j = 0; j < DEPTH - 1; j++) begin
      in_data = DW'(j);
      @(negedge clock);
    end
    in_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_idle_ignore();
    reset = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = DW'(9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if ({in_ready, ena, wea, busy} !== 4'b0 || count !== '0) begin
        errors++;
        $display("FAIL idle_ignore[%0d]: in_ready=%b ena=%b wea=%b busy=%b count=%0d want 0 0 0 0 0",
                 c, in_ready, ena, wea, busy, count);
      end
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ena !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL idle_start_valid: busy=%b ena=%b count=%0d want 1 0 0", busy, ena, count);
    end
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (ena !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL idle_after_start: ena=%b count=%0d want 0 0", ena, count);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_run();
    test_wrap();
    test_idle_ignore();
    @(negedge clock);
    checks++;
    if (bad_we !== 0) begin
      errors++;
      $display("FAIL wea_without_ena: %0d cycles want 0", bad_we);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
